// File: rtl/color_bar_generator.sv
// color_bar_generator
// Free-running raster timing and test-pattern source that emulates an 8-bit
// parallel camera sensor. Produces FV/LV framing, hsync/vsync pulses and an
// 8-bit YUV422 (UYVY) colour-bar pattern or a byte ramp.
//
// Ports:
//   clk   - pixel/byte clock, all logic on the rising edge
//   rstn  - synchronous reset, active-high (historical name)
//   fv    - frame valid
//   lv    - line valid
//   data  - pixel byte, 8'h00 whenever lv is low
//   vsync - vertical sync pulse, active-high, whole lines
//   hsync - horizontal sync pulse, active-high
//
// All outputs are registered decodes of the raster counters, so every output
// lags the counter position it describes by one clock.
module color_bar_generator #(
  parameter int unsigned h_active      = 480,
  parameter int unsigned h_total       = 800,
  parameter int unsigned v_active      = 800,
  parameter int unsigned v_total       = 830,
  parameter int unsigned H_FRONT_PORCH = 40,
  parameter int unsigned H_SYNCH       = 44,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter int unsigned V_SYNCH       = 5,
  parameter int unsigned mode          = 1
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       fv,
  output logic       lv,
  output logic [7:0] data,
  output logic       vsync,
  output logic       hsync
);

  // One extra bit so the sync end positions (which may equal the total)
  // are always representable.
  localparam int unsigned HW = $clog2(h_total + 1);
  localparam int unsigned VW = $clog2(v_total + 1);

  localparam int unsigned HS_START = h_active + H_FRONT_PORCH;
  localparam int unsigned HS_END   = h_active + H_FRONT_PORCH + H_SYNCH;
  localparam int unsigned VS_START = v_active + V_FRONT_PORCH;
  localparam int unsigned VS_END   = v_active + V_FRONT_PORCH + V_SYNCH;
  localparam int unsigned BAR_W    = h_active / 8;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic          fv_c;
  logic          lv_c;
  logic          hsync_c;
  logic          vsync_c;
  logic [7:0]    data_c;
  logic [HW-1:0] bar_full;
  logic [2:0]    bar;
  logic [7:0]    bar_y;
  logic [7:0]    bar_u;
  logic [7:0]    bar_v;
  logic [7:0]    bar_byte;

  // Timing decode from the current counter position
  always_comb begin
    fv_c    = (vcnt < VW'(v_active));
    lv_c    = fv_c && (hcnt < HW'(h_active));
    hsync_c = (hcnt >= HW'(HS_START)) && (hcnt < HW'(HS_END));
    vsync_c = (vcnt >= VW'(VS_START)) && (vcnt < VW'(VS_END));
  end

  // Bar index: 8 equal-width bars across the active line
  assign bar_full = hcnt / HW'(BAR_W);
  assign bar      = bar_full[2:0];

  always_comb begin
    bar_y = 8'h10;
    bar_u = 8'h80;
    bar_v = 8'h80;
    case (bar)
      3'd0: begin bar_y = 8'hB4; bar_u = 8'h80; bar_v = 8'h80; end // white
      3'd1: begin bar_y = 8'hA2; bar_u = 8'h2C; bar_v = 8'h8E; end // yellow
      3'd2: begin bar_y = 8'h83; bar_u = 8'h9C; bar_v = 8'h2C; end // cyan
      3'd3: begin bar_y = 8'h70; bar_u = 8'h48; bar_v = 8'h3A; end // green
      3'd4: begin bar_y = 8'h54; bar_u = 8'hB8; bar_v = 8'hC6; end // magenta
      3'd5: begin bar_y = 8'h41; bar_u = 8'h64; bar_v = 8'hD4; end // red
      3'd6: begin bar_y = 8'h23; bar_u = 8'hD4; bar_v = 8'h72; end // blue
      default: begin bar_y = 8'h10; bar_u = 8'h80; bar_v = 8'h80; end // black
    endcase
  end

  // UYVY byte order within each 4-byte group
  always_comb begin
    bar_byte = bar_y;
    case (hcnt[1:0])
      2'd0:    bar_byte = bar_u;
      2'd1:    bar_byte = bar_y;
      2'd2:    bar_byte = bar_v;
      default: bar_byte = bar_y;
    endcase
  end

  always_comb begin
    data_c = '0;
    if (lv_c) begin
      if (mode == 1) data_c = bar_byte;
      else           data_c = 8'(hcnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      hcnt  <= '0;
      vcnt  <= '0;
      fv    <= 1'b0;
      lv    <= 1'b0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      data  <= '0;
    end else begin
      if (hcnt == HW'(h_total - 1)) begin
        hcnt <= '0;
        if (vcnt == VW'(v_total - 1)) vcnt <= '0;
        else                          vcnt <= vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      fv    <= fv_c;
      lv    <= lv_c;
      hsync <= hsync_c;
      vsync <= vsync_c;
      data  <= data_c;
    end
  end

endmodule

// File: tb/tb_color_bar_generator.sv
// Testbench for color_bar_generator: a scaled-down raster (288 active bytes so
// the ramp wraps, 14 lines per frame) with one bar instance and one ramp
// instance sharing clock and reset.
module tb_color_bar_generator;

  localparam int HA  = 288;
  localparam int HT  = 360;
  localparam int VA  = 8;
  localparam int VT  = 14;
  localparam int HFP = 16;
  localparam int HS  = 20;
  localparam int VFP = 2;
  localparam int VS  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       fv_b, lv_b, hs_b, vs_b;
  logic [7:0] d_b;
  logic       fv_r, lv_r, hs_r, vs_r;
  logic [7:0] d_r;

  color_bar_generator #(
    .h_active(HA), .h_total(HT), .v_active(VA), .v_total(VT),
    .H_FRONT_PORCH(HFP), .H_SYNCH(HS), .V_FRONT_PORCH(VFP), .V_SYNCH(VS),
    .mode(1)
  ) u_bars (
    .clk(clk), .rstn(rst), .fv(fv_b), .lv(lv_b), .data(d_b),
    .vsync(vs_b), .hsync(hs_b)
  );

  color_bar_generator #(
    .h_active(HA), .h_total(HT), .v_active(VA), .v_total(VT),
    .H_FRONT_PORCH(HFP), .H_SYNCH(HS), .V_FRONT_PORCH(VFP), .V_SYNCH(VS),
    .mode(0)
  ) u_ramp (
    .clk(clk), .rstn(rst), .fv(fv_r), .lv(lv_r), .data(d_r),
    .vsync(vs_r), .hsync(hs_r)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour bars, UYVY order
  function automatic logic [7:0] bar_byte(input int h);
    logic [7:0] y, u, v;
    case (h / (HA / 8))
      0: {y, u, v} = 24'hB48080;
      1: {y, u, v} = 24'hA22C8E;
      2: {y, u, v} = 24'h839C2C;
      3: {y, u, v} = 24'h70483A;
      4: {y, u, v} = 24'h54B8C6;
      5: {y, u, v} = 24'h4164D4;
      6: {y, u, v} = 24'h23D472;
      default: {y, u, v} = 24'h108080;
    endcase
    case (h % 4)
      0: return u;
      2: return v;
      default: return y;
    endcase
  endfunction

  // Scoreboard: one expectation pushed per clock edge, popped half a cycle later
  typedef struct packed {
    logic       fv;
    logic       lv;
    logic       hs;
    logic       vs;
    logic [7:0] db;
    logic [7:0] dr;
  } exp_t;

  exp_t sbq[$];
  int   mh = 0;
  int   mv = 0;

  always @(posedge clk) begin
    exp_t e;
    int nh, nv;
    e  = '0;
    nh = 0;
    nv = 0;
    if (!rst) begin
      e.fv = (mv < VA);
      e.lv = e.fv && (mh < HA);
      e.hs = (mh >= HA + HFP) && (mh < HA + HFP + HS);
      e.vs = (mv >= VA + VFP) && (mv < VA + VFP + VS);
      e.db = e.lv ? bar_byte(mh) : 8'h00;
      e.dr = e.lv ? 8'(mh) : 8'h00;
      nh = mh + 1;
      nv = mv;
      if (nh == HT) begin
        nh = 0;
        nv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end
    mh <= nh;
    mv <= nv;
    sbq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("sb_fv",    fv_b, e.fv);
      check("sb_lv",    lv_b, e.lv);
      check("sb_hsync", hs_b, e.hs);
      check("sb_vsync", vs_b, e.vs);
      check("sb_bars",  d_b,  e.db);
      check("sb_ramp",  d_r,  e.dr);
      check("sb_ramp_lv", lv_r, e.lv);
      check("lv_without_fv", lv_b & ~fv_b, 1'b0);
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] db;
    logic [7:0] dr;
  } vec_t;

  vec_t       tbl[16];
  logic [7:0] cap_b[HT];
  logic [7:0] cap_r[HT];

  task automatic check_zero(input string tag);
    check({tag, "_fv"},   fv_b, 1'b0);
    check({tag, "_lv"},   lv_b, 1'b0);
    check({tag, "_hs"},   hs_b, 1'b0);
    check({tag, "_vs"},   vs_b, 1'b0);
    check({tag, "_data"}, d_b,  8'h00);
    check({tag, "_ramp"}, d_r,  8'h00);
  endtask

  task automatic check_first(input string tag);
    check({tag, "_fv"},   fv_b, 1'b1);
    check({tag, "_lv"},   lv_b, 1'b1);
    check({tag, "_data"}, d_b,  8'h80);
    check({tag, "_ramp"}, d_r,  8'h00);
  endtask

  initial begin
    int lv_cnt, fv_cnt, hs_cnt, vs_cnt, first_hs, first_vs;
    bit found;

    tbl[0]  = '{0,   8'h80, 8'h00};
    tbl[1]  = '{1,   8'hB4, 8'h01};
    tbl[2]  = '{2,   8'h80, 8'h02};
    tbl[3]  = '{3,   8'hB4, 8'h03};
    tbl[4]  = '{36,  8'h2C, 8'h24};
    tbl[5]  = '{37,  8'hA2, 8'h25};
    tbl[6]  = '{38,  8'h8E, 8'h26};
    tbl[7]  = '{39,  8'hA2, 8'h27};
    tbl[8]  = '{144, 8'hB8, 8'h90};
    tbl[9]  = '{146, 8'hC6, 8'h92};
    tbl[10] = '{252, 8'h80, 8'hFC};
    tbl[11] = '{253, 8'h10, 8'hFD};
    tbl[12] = '{255, 8'h10, 8'hFF};
    tbl[13] = '{256, 8'h80, 8'h00};
    tbl[14] = '{287, 8'h10, 8'h1F};
    tbl[15] = '{288, 8'h00, 8'h00};

    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("release");
    @(negedge clk);
    check_zero("release_plus1");

    lv_cnt = 0; fv_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    first_hs = -1; first_vs = -1;
    for (int i = 0; i < HT * VT; i++) begin
      @(negedge clk);
      if (i == 0) check_first("first_pixel");
      if (i < HT) begin
        cap_b[i] = d_b;
        cap_r[i] = d_r;
      end
      lv_cnt += int'(lv_b);
      fv_cnt += int'(fv_b);
      hs_cnt += int'(hs_b);
      vs_cnt += int'(vs_b);
      if (hs_b && first_hs < 0) first_hs = i;
      if (vs_b && first_vs < 0) first_vs = i;
    end
    check("lv_clocks_per_frame", lv_cnt, VA * HA);
    check("fv_clocks_per_frame", fv_cnt, VA * HT);
    check("hsync_clocks",        hs_cnt, VT * HS);
    check("vsync_clocks",        vs_cnt, VS * HT);
    check("hsync_first_pos",     first_hs, HA + HFP);
    check("vsync_first_pos",     first_vs, (VA + VFP) * HT);

    foreach (tbl[k]) begin
      check($sformatf("bars_byte%0d", tbl[k].idx), cap_b[tbl[k].idx], tbl[k].db);
      check($sformatf("ramp_byte%0d", tbl[k].idx), cap_r[tbl[k].idx], tbl[k].dr);
    end

    // Mid-frame reset partway through line 3 of the next frame
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      @(negedge clk);
      if (mv == 3 && mh == 100) found = 1'b1;
    end
    check("wait_midframe", found, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 check_zero("midframe_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("midframe_release");
    @(negedge clk);
    check_zero("midframe_release_plus1");
    @(negedge clk);
    check_first("restart_pixel");
    check("restart_hsync", hs_b, 1'b0);
    check("restart_vsync", vs_b, 1'b0);

    repeat (HT * VT) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
